// File: rtl/ocb_pkg.sv
// Shared definitions for the on-chip register bus arbiter.
// Holds the FSM state encoding and the default bus widths.
package ocb_pkg;

    localparam int OCB_ADDR_W = 16;
    localparam int OCB_DATA_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } ocb_state_e;

endpackage

// File: rtl/ocb_rr_arb2.sv
// Two-way round-robin pick with its last_grant register.
// Ports:
//   clk, rst_n    clock / async active-low reset
//   req_i[1:0]    request vector, bit n = master n
//   grant_en_i    high when the owner FSM accepts the pick this cycle
//   pick_o[1:0]   one-hot winner (combinational), 00 when no request
module ocb_rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req_i,
    input  logic       grant_en_i,
    output logic [1:0] pick_o
);

    // Index of the master granted last; resets to 1 so m0 wins the first tie.
    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        pick_o       = 2'b00;
        last_grant_d = last_grant_q;
        case (req_i)
            2'b01:   pick_o = 2'b01;
            2'b10:   pick_o = 2'b10;
            2'b11:   pick_o = last_grant_q ? 2'b01 : 2'b10;
            default: pick_o = 2'b00;
        endcase
        if (grant_en_i && (pick_o != 2'b00)) begin
            last_grant_d = pick_o[1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/ocb_arbiter.sv
// Two-master arbiter / sequencer for the 16-bit bus2ip register bus.
// Each granted access becomes one rd/wr strobe; reads wait RD_LATENCY
// cycles for ip2bus data, then the winner gets a one-cycle ack.
// Ports:
//   clk, rst_n                       clock / async active-low reset
//   m{0,1}_req_i/_we_i/_addr_i/_wdata_i  master request side
//   m{0,1}_ack_o/_rdata_o            completion pulse / read data
//   bus2ip_addr_o/_data_o            bus address / write data
//   bus2ip_rd_ce_o/_wr_ce_o          single-cycle strobes
//   ip2bus_data_i                    slave read data
//   grant_o                          one-hot owner, 00 in IDLE
//   busy_o                           high outside IDLE
//
// state | meaning
// IDLE  | sample requests, latch winner's access
// ISSUE | one-cycle rd/wr strobe
// WAIT  | count down read latency, capture read data at zero
// ACK   | one-cycle ack to the owner
module ocb_arbiter
    import ocb_pkg::*;
#(
    parameter int ADDR_W     = OCB_ADDR_W,
    parameter int DATA_W     = OCB_DATA_W,
    parameter int RD_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [ADDR_W-1:0] bus2ip_addr_o,
    output logic [DATA_W-1:0] bus2ip_data_o,
    output logic              bus2ip_rd_ce_o,
    output logic              bus2ip_wr_ce_o,
    input  logic [DATA_W-1:0] ip2bus_data_i,
    output logic [1:0]        grant_o,
    output logic              busy_o
);

    // Counter starts at RD_LATENCY-1 after the strobe so the capture lands
    // exactly RD_LATENCY cycles after ISSUE.
    localparam logic [3:0] CNT_LOAD = 4'(RD_LATENCY - 1);

    ocb_state_e        state_q, state_d;
    logic [1:0]        grant_q, grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              we_q, we_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic [1:0]        pick;

    ocb_rr_arb2 u_rr (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      ({m1_req_i, m0_req_i}),
        .grant_en_i (state_q == IDLE),
        .pick_o     (pick)
    );

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        we_d       = we_q;
        cnt_d      = cnt_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        case (state_q)
            IDLE: begin
                if (pick != 2'b00) begin
                    grant_d = pick;
                    if (pick[0]) begin
                        addr_d  = m0_addr_i;
                        wdata_d = m0_wdata_i;
                        we_d    = m0_we_i;
                    end else begin
                        addr_d  = m1_addr_i;
                        wdata_d = m1_wdata_i;
                        we_d    = m1_we_i;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = ACK;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (grant_q[0]) begin
                        m0_rdata_d = ip2bus_data_i;
                    end else begin
                        m1_rdata_d = ip2bus_data_i;
                    end
                    state_d = ACK;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            grant_q    <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            cnt_q      <= 4'd0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
        end
    end

    // Strobes, acks and grant decode straight from the state register so an
    // async reset drops them in the same cycle.
    assign bus2ip_rd_ce_o = (state_q == ISSUE) && !we_q;
    assign bus2ip_wr_ce_o = (state_q == ISSUE) && we_q;
    assign m0_ack_o       = (state_q == ACK) && grant_q[0];
    assign m1_ack_o       = (state_q == ACK) && grant_q[1];
    assign grant_o        = (state_q == IDLE) ? 2'b00 : grant_q;
    assign busy_o         = (state_q != IDLE);
    assign bus2ip_addr_o  = addr_q;
    assign bus2ip_data_o  = wdata_q;
    assign m0_rdata_o     = m0_rdata_q;
    assign m1_rdata_o     = m1_rdata_q;

endmodule

// File: tb/tb_ocb_arbiter.sv
module tb_ocb_arbiter;

    localparam int L0 = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [15:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack, rd_ce, wr_ce, busy;
    logic [15:0] m0_rdata, m1_rdata, b_addr, b_data, ip_data;
    logic [1:0]  grant;

    logic        m0_req_b;
    logic [15:0] m0_addr_b, z16;
    logic        m0_ack_b, m1_ack_b, rd_ce_b, wr_ce_b, busy_b;
    logic [15:0] m0_rdata_b, m1_rdata_b, b_addr_b, b_data_b, ip_data_b;
    logic [1:0]  grant_b;
    logic        zero;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ocb_arbiter #(.RD_LATENCY(L0)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_ack_o(m0_ack), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_ack_o(m1_ack), .m1_rdata_o(m1_rdata),
        .bus2ip_addr_o(b_addr), .bus2ip_data_o(b_data),
        .bus2ip_rd_ce_o(rd_ce), .bus2ip_wr_ce_o(wr_ce),
        .ip2bus_data_i(ip_data), .grant_o(grant), .busy_o(busy)
    );

    ocb_arbiter #(.RD_LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .m0_req_i(m0_req_b), .m0_we_i(zero), .m0_addr_i(m0_addr_b), .m0_wdata_i(z16),
        .m0_ack_o(m0_ack_b), .m0_rdata_o(m0_rdata_b),
        .m1_req_i(zero), .m1_we_i(zero), .m1_addr_i(z16), .m1_wdata_i(z16),
        .m1_ack_o(m1_ack_b), .m1_rdata_o(m1_rdata_b),
        .bus2ip_addr_o(b_addr_b), .bus2ip_data_o(b_data_b),
        .bus2ip_rd_ce_o(rd_ce_b), .bus2ip_wr_ce_o(wr_ce_b),
        .ip2bus_data_i(ip_data_b), .grant_o(grant_b), .busy_o(busy_b)
    );

    function automatic logic [15:0] slave_val(input logic [15:0] a);
        case (a)
            16'h0020: return 16'h1234;
            16'h0030: return 16'hBEEF;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    // Slave model: data is valid only in the cycle RD_LATENCY after the strobe.
    logic [3:0]  pipe   = '0;
    logic [3:0]  pipe_b = '0;
    logic [15:0] s_addr   = '0;
    logic [15:0] s_addr_b = '0;
    always @(posedge clk) begin
        pipe   <= {pipe[2:0], rd_ce};
        pipe_b <= {pipe_b[2:0], rd_ce_b};
        if (rd_ce)   s_addr   <= b_addr;
        if (rd_ce_b) s_addr_b <= b_addr_b;
    end
    assign ip_data   = pipe[L0-1] ? slave_val(s_addr)   : 16'hDEAD;
    assign ip_data_b = pipe_b[0]  ? slave_val(s_addr_b) : 16'hDEAD;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        mst;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
        int          exp_ack;
    } vec_t;

    vec_t vecs[5];

    task automatic run_txn(input string tag, input vec_t v);
        int          sc, ac, ns;
        logic        other, s_wr;
        logic [15:0] sa, sd, rd;
        logic [1:0]  sg;
        sc = -1; ac = -1; ns = 0; other = 1'b0;
        s_wr = 1'b0; sa = '0; sd = '0; rd = '0; sg = '0;
        @(posedge clk); #1;
        if (!v.mst) begin
            m0_req = 1'b1; m0_we = v.we; m0_addr = v.addr; m0_wdata = v.wdata;
        end else begin
            m1_req = 1'b1; m1_we = v.we; m1_addr = v.addr; m1_wdata = v.wdata;
        end
        for (int c = 0; c < 20 && ac < 0; c++) begin
            @(negedge clk);
            ns += int'(rd_ce) + int'(wr_ce);
            if (rd_ce || wr_ce) begin
                sc = c; s_wr = wr_ce; sa = b_addr; sd = b_data; sg = grant;
            end
            if (v.mst ? m0_ack : m1_ack) other = 1'b1;
            if (v.mst ? m1_ack : m0_ack) begin
                ac = c;
                rd = v.mst ? m1_rdata : m0_rdata;
                m0_req = 1'b0; m1_req = 1'b0;
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        check({tag, " strobe_cycle"}, sc, 1);
        check({tag, " strobe_count"}, ns, 1);
        check({tag, " strobe_kind"}, s_wr, v.we);
        check({tag, " addr"}, sa, v.addr);
        if (v.we) check({tag, " wdata"}, sd, v.wdata);
        check({tag, " grant"}, sg, v.mst ? 2'b10 : 2'b01);
        check({tag, " ack_cycle"}, ac, v.exp_ack);
        check({tag, " other_ack"}, other, 1'b0);
        if (!v.we) check({tag, " rdata"}, rd, v.exp_rdata);
        @(negedge clk);
        check({tag, " idle_after"}, {busy, grant}, 3'b000);
    endtask

    initial begin
        int          k, a, na, ns, sc, ac;
        logic        two;
        logic [1:0]  exp_g[4];
        int          exp_sc[4];
        logic [15:0] rv, ea;

        vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'hA5A5, 16'h0000, 2};
        vecs[1] = '{1'b1, 1'b0, 16'h0020, 16'h0000, 16'h1234, 4};
        vecs[2] = '{1'b1, 1'b1, 16'h0040, 16'h0F0F, 16'h0000, 2};
        vecs[3] = '{1'b0, 1'b0, 16'h0030, 16'h0000, 16'hBEEF, 4};
        vecs[4] = '{1'b0, 1'b0, 16'h0077, 16'h0000, 16'h5A2D, 4};
        exp_g  = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_sc = '{1, 6, 11, 16};

        rst_n = 1'b0; zero = 1'b0; z16 = '0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        m0_req_b = 0; m0_addr_b = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ctrl", {m0_ack, m1_ack, rd_ce, wr_ce, grant, busy}, 7'd0);
        check("reset bus", {b_addr, b_data}, 32'd0);
        check("reset rdata", {m0_rdata, m1_rdata}, 32'd0);
        rst_n = 1'b1;

        // Both masters reading continuously from reset: m0, m1, m0, m1.
        k = 0; a = 0; two = 1'b0;
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 16'h0100;
        m1_req = 1; m1_we = 0; m1_addr = 16'h0200;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (rd_ce && wr_ce) two = 1'b1;
            if ((rd_ce || wr_ce) && k < 4) begin
                ea = exp_g[k][0] ? 16'h0100 : 16'h0200;
                check($sformatf("rr strobe_cycle %0d", k), c, exp_sc[k]);
                check($sformatf("rr grant %0d", k), grant, exp_g[k]);
                check($sformatf("rr addr %0d", k), b_addr, ea);
                k++;
            end
            if ((m0_ack || m1_ack) && a < 4) begin
                rv = exp_g[a][0] ? m0_rdata : m1_rdata;
                check($sformatf("rr ack_owner %0d", a), {m1_ack, m0_ack}, exp_g[a]);
                check($sformatf("rr ack_cycle %0d", a), c, exp_sc[a] + 3);
                check($sformatf("rr rdata %0d", a), rv, exp_g[a][0] ? 16'h5B5A : 16'h585A);
                a++;
                if (a == 4) begin
                    m0_req = 0; m1_req = 0;
                end
            end
        end
        check("rr strobes", k, 4);
        check("rr acks", a, 4);
        check("rr two_strobes", two, 1'b0);

        foreach (vecs[i]) run_txn($sformatf("vec%0d", i), vecs[i]);
        check("m1 rdata held", m1_rdata, 16'h1234);

        // Request dropped during WAIT still completes once.
        na = 0; ns = 0; ac = -1;
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 16'h0050;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c == 2) m0_req = 0;
            ns += int'(rd_ce) + int'(wr_ce);
            if (m0_ack) begin na++; ac = c; end
            if (m1_ack) na += 10;
            if (c == 6) check("wd idle", {busy, grant}, 3'b000);
        end
        check("wd acks", na, 1);
        check("wd ack_cycle", ac, 4);
        check("wd strobes", ns, 1);
        check("wd rdata", m0_rdata, 16'h5A0A);

        // Reset during WAIT aborts with no ack.
        @(posedge clk); #1;
        m0_req = 1; m0_we = 0; m0_addr = 16'h0060;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst ctrl", {m0_ack, m1_ack, rd_ce, wr_ce, grant, busy}, 7'd0);
        check("rst bus", {b_addr, b_data}, 32'd0);
        check("rst rdata", {m0_rdata, m1_rdata}, 32'd0);
        m0_req = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        na = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            na += int'(m0_ack) + int'(m1_ack) + int'(rd_ce) + int'(wr_ce);
        end
        check("rst no_activity", na, 0);
        run_txn("post_rst", vecs[1]);

        // RD_LATENCY = 1 build.
        sc = -1; ac = -1; rv = '0;
        @(posedge clk); #1;
        m0_req_b = 1; m0_addr_b = 16'h0030;
        for (int c = 0; c < 10 && ac < 0; c++) begin
            @(negedge clk);
            if (rd_ce_b) sc = c;
            if (c == 2) check("l1 wait", {busy_b, m0_ack_b}, 2'b10);
            if (m0_ack_b) begin ac = c; rv = m0_rdata_b; m0_req_b = 0; end
        end
        m0_req_b = 0;
        check("l1 strobe_cycle", sc, 1);
        check("l1 ack_cycle", ac, 3);
        check("l1 rdata", rv, 16'hBEEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
